// File: rtl/fc_weight_loader.sv
// Weight loader for the binarized FC layer: scatters a compacted serial weight
// stream into the full connection vector and presents it double-buffered.
module fc_weight_loader #(
   parameter int                       ISIZE = 10,
   parameter int                       LSIZE = 10,
   parameter logic [LSIZE*ISIZE-1:0]   VALID = '1,
   parameter int                       WW    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [WW-1:0]            w_data,
   input  logic                     w_valid,
   output logic                     w_ready,
   output logic [LSIZE*ISIZE-1:0]   e_weights,
   output logic                     e_valid,
   input  logic                     e_ack,
   output logic                     busy
);

   localparam int N = LSIZE * ISIZE;

   // Number of enabled connections strictly below position p.
   function automatic int count_below(input int p);
      int n;
      n = 0;
      for (int i = 0; i < p; i++) begin
         if (VALID[i]) n++;
      end
      return n;
   endfunction

   localparam int NV = count_below(N);
   localparam int NW = (NV + WW - 1) / WW;
   localparam int CW = (NW > 0) ? $clog2(NW + 1) : 1;
   localparam logic [CW-1:0] LASTW = CW'((NW > 0) ? NW - 1 : 0);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

   state_t           state;
   logic [N-1:0]     shadow;
   logic [N-1:0]     merged;
   logic [CW-1:0]    word_cnt;

   // Each enabled position owns a fixed (word, bit) slot of the compacted stream,
   // so the scatter is pure wiring selected by word_cnt.
   for (genvar p = 0; p < N; p++) begin : g_pos
      if (VALID[p]) begin : g_on
         localparam int            C    = count_below(p);
         localparam logic [CW-1:0] WIDX = CW'(C / WW);
         localparam int            BIDX = C % WW;
         assign merged[p] = (word_cnt == WIDX) ? w_data[BIDX] : shadow[p];
      end else begin : g_off
         // Never written from the stream, so this bit stays at its cleared zero.
         assign merged[p] = shadow[p];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         w_ready   <= 1'b0;
         e_valid   <= 1'b0;
         busy      <= 1'b0;
         e_weights <= '0;
         shadow    <= '0;
         word_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shadow   <= '0;
                  word_cnt <= '0;
                  busy     <= 1'b1;
                  if (NV == 0) begin
                     state     <= HOLD;
                     e_weights <= '0;
                     e_valid   <= 1'b1;
                  end else begin
                     state   <= LOAD;
                     w_ready <= 1'b1;
                  end
               end
            end
            LOAD: begin
               // abort wins over a same-cycle transfer; the presented vector is untouched.
               if (abort) begin
                  state    <= IDLE;
                  w_ready  <= 1'b0;
                  busy     <= 1'b0;
                  shadow   <= '0;
                  word_cnt <= '0;
               end else if (w_valid) begin
                  shadow   <= merged;
                  word_cnt <= word_cnt + 1'b1;
                  if (word_cnt == LASTW) begin
                     state     <= HOLD;
                     w_ready   <= 1'b0;
                     e_weights <= merged;
                     e_valid   <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (e_ack) begin
                  state   <= IDLE;
                  e_valid <= 1'b0;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               w_ready <= 1'b0;
               e_valid <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_weight_loader.sv
// Directed bench for fc_weight_loader: a sparse-mask instance (8 positions, 4-bit
// words) with hand-computed vectors, and a default instance checked against the raw stream.
module tb_fc_weight_loader;

   logic clk;
   logic rst;

   logic         s_start, s_abort, s_w_valid, s_w_ready, s_e_valid, s_e_ack, s_busy;
   logic [3:0]   s_w_data;
   logic [7:0]   s_e_weights;

   logic         d_start, d_abort, d_w_valid, d_w_ready, d_e_valid, d_e_ack, d_busy;
   logic [7:0]   d_w_data;
   logic [99:0]  d_e_weights;

   int vec_count = 0;
   int err_count = 0;

   typedef struct {
      logic [3:0] w0;
      logic [3:0] w1;
      logic [7:0] expect_w;
   } vec_t;

   vec_t vecs [6];

   fc_weight_loader #(.ISIZE(4), .LSIZE(2), .VALID(8'b1011_0110), .WW(4)) u_small (
      .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
      .w_data(s_w_data), .w_valid(s_w_valid), .w_ready(s_w_ready),
      .e_weights(s_e_weights), .e_valid(s_e_valid), .e_ack(s_e_ack), .busy(s_busy)
   );

   fc_weight_loader #(.ISIZE(10), .LSIZE(10), .VALID({100{1'b1}}), .WW(8)) u_dflt (
      .clk(clk), .rst(rst), .start(d_start), .abort(d_abort),
      .w_data(d_w_data), .w_valid(d_w_valid), .w_ready(d_w_ready),
      .e_weights(d_e_weights), .e_valid(d_e_valid), .e_ack(d_e_ack), .busy(d_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      vec_count++;
      if (act !== exp) begin
         err_count++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_small(input string name, input logic rdy, input logic vld,
                              input logic bsy, input logic [7:0] w);
      check_output({name, ".w_ready"}, 128'(s_w_ready), 128'(rdy));
      check_output({name, ".e_valid"}, 128'(s_e_valid), 128'(vld));
      check_output({name, ".busy"}, 128'(s_busy), 128'(bsy));
      check_output({name, ".e_weights"}, 128'(s_e_weights), 128'(w));
   endtask

   task automatic apply_start();
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
   endtask

   task automatic apply_word(input logic [3:0] d);
      s_w_valid = 1'b1;
      s_w_data  = d;
      tick();
      s_w_valid = 1'b0;
      s_w_data  = '0;
   endtask

   task automatic apply_ack();
      s_e_ack = 1'b1;
      tick();
      s_e_ack = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [3:0] w0, input logic [3:0] w1);
      apply_start();
      apply_word(w0);
      apply_word(w1);
   endtask

   initial begin
      logic [103:0] stream;
      logic [7:0]   word;

      // Mask 1011_0110 enables positions 1,2,4,5,7 in stream order.
      vecs[0] = '{4'b1011, 4'b1111, 8'hA6};
      vecs[1] = '{4'b1111, 4'b0001, 8'hB6};
      vecs[2] = '{4'b0101, 4'b0000, 8'h12};
      vecs[3] = '{4'b1010, 4'b1110, 8'h24};
      vecs[4] = '{4'b0000, 4'b0001, 8'h80};
      vecs[5] = '{4'b1000, 4'b1110, 8'h20};

      rst = 1'b0;
      s_start = 0; s_abort = 0; s_w_valid = 0; s_w_data = '0; s_e_ack = 0;
      d_start = 0; d_abort = 0; d_w_valid = 0; d_w_data = '0; d_e_ack = 0;
      tick();
      tick();
      check_small("reset", 1'b0, 1'b0, 1'b0, 8'h00);
      check_output("reset.dflt_busy", 128'(d_busy), 128'(0));
      check_output("reset.dflt_weights", 128'(d_e_weights), 128'(0));
      #3;
      rst = 1'b1;
      tick();

      // Sparse scatter with excess bits in the final word.
      s_w_valid = 1'b1;
      s_w_data  = 4'hF;
      tick();
      s_w_valid = 1'b0;
      check_small("idle_wvalid", 1'b0, 1'b0, 1'b0, 8'h00);
      apply_start();
      check_small("load_entry", 1'b1, 1'b0, 1'b1, 8'h00);
      apply_word(4'b1011);
      check_small("after_word0", 1'b1, 1'b0, 1'b1, 8'h00);
      apply_word(4'b1111);
      check_small("after_word1", 1'b0, 1'b1, 1'b1, 8'hA6);

      // Hold until acknowledged.
      for (int i = 0; i < 10; i++) begin
         tick();
         check_small("hold_wait", 1'b0, 1'b1, 1'b1, 8'hA6);
      end
      apply_ack();
      check_small("after_ack", 1'b0, 1'b0, 1'b0, 8'hA6);
      apply_ack();
      check_small("ack_in_idle", 1'b0, 1'b0, 1'b0, 8'hA6);

      // Double buffering across a stalled load.
      apply_start();
      apply_word(4'b0000);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_small("stall", 1'b1, 1'b0, 1'b1, 8'hA6);
      end
      apply_word(4'b0000);
      check_small("dbuf_done", 1'b0, 1'b1, 1'b1, 8'h00);
      apply_ack();

      for (int v = 0; v < 6; v++) begin
         apply_stimulus(vecs[v].w0, vecs[v].w1);
         check_small($sformatf("vec%0d", v), 1'b0, 1'b1, 1'b1, vecs[v].expect_w);
         apply_ack();
         check_small($sformatf("vec%0d_ack", v), 1'b0, 1'b0, 1'b0, vecs[v].expect_w);
      end

      // start during LOAD must not restart the load.
      apply_start();
      apply_word(4'b1011);
      apply_start();
      check_small("start_in_load", 1'b1, 1'b0, 1'b1, 8'h20);
      apply_word(4'b1111);
      check_small("start_in_load_done", 1'b0, 1'b1, 1'b1, 8'hA6);
      apply_ack();

      // start and e_ack together in HOLD: ack wins.
      apply_stimulus(4'b0101, 4'b0000);
      s_start = 1'b1;
      s_e_ack = 1'b1;
      tick();
      s_start = 1'b0;
      s_e_ack = 1'b0;
      check_small("start_ack_hold", 1'b0, 1'b0, 1'b0, 8'h12);
      tick();
      check_small("start_ack_idle", 1'b0, 1'b0, 1'b0, 8'h12);

      // Abort with a simultaneous word.
      apply_start();
      apply_word(4'b1111);
      s_abort   = 1'b1;
      s_w_valid = 1'b1;
      s_w_data  = 4'b1111;
      tick();
      s_abort   = 1'b0;
      s_w_valid = 1'b0;
      check_small("abort", 1'b0, 1'b0, 1'b0, 8'h12);
      apply_stimulus(4'b1010, 4'b1110);
      check_small("after_abort_load", 1'b0, 1'b1, 1'b1, 8'h24);
      s_abort = 1'b1;
      tick();
      s_abort = 1'b0;
      check_small("abort_in_hold", 1'b0, 1'b1, 1'b1, 8'h24);
      apply_ack();

      // Asynchronous reset in LOAD and in HOLD.
      apply_start();
      apply_word(4'b1011);
      rst = 1'b0;
      #1;
      check_small("rst_in_load", 1'b0, 1'b0, 1'b0, 8'h00);
      #3;
      rst = 1'b1;
      tick();
      apply_stimulus(4'b0000, 4'b0001);
      check_small("post_rst_load", 1'b0, 1'b1, 1'b1, 8'h80);
      rst = 1'b0;
      #1;
      check_small("rst_in_hold", 1'b0, 1'b0, 1'b0, 8'h00);
      #3;
      rst = 1'b1;
      tick();
      apply_stimulus(4'b1000, 4'b1110);
      check_small("post_rst_hold", 1'b0, 1'b1, 1'b1, 8'h20);
      apply_ack();

      // Default instance: all-ones mask, 13 words, top nibble of the last word unused.
      d_start = 1'b1;
      tick();
      d_start = 1'b0;
      stream = '0;
      for (int i = 0; i < 13; i++) begin
         word = 8'($urandom);
         if (i == 12) word[7:4] = 4'hF;
         stream[i*8 +: 8] = word;
         d_w_valid = 1'b1;
         d_w_data  = word;
         tick();
         d_w_valid = 1'b0;
         if (i == 11) begin
            check_output("dflt_valid_early", 128'(d_e_valid), 128'(0));
            check_output("dflt_weights_early", 128'(d_e_weights), 128'(0));
         end
      end
      check_output("dflt_valid", 128'(d_e_valid), 128'(1));
      check_output("dflt_ready", 128'(d_w_ready), 128'(0));
      check_output("dflt_weights", 128'(d_e_weights), 128'(stream[99:0]));
      d_e_ack = 1'b1;
      tick();
      d_e_ack = 1'b0;
      check_output("dflt_ack_busy", 128'(d_busy), 128'(0));
      check_output("dflt_ack_weights", 128'(d_e_weights), 128'(stream[99:0]));

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule

// File: doc/fc_weight_loader.md
Name: fc_weight_loader

Overview:
- Writer side of the binarized FC layer's evaluator-weight interface.
- Receives a compacted serial stream of weight bits containing only the positions whose VALID mask bit is 1.
- Scatters them into the full LSIZE*ISIZE weight vector; non-valid positions are zero.
- Presents the vector through a valid/ack handshake to the XNOR-popcount layer's e_input.
- Double-buffered: the presented vector stays stable while the next one loads.

Parameters:
- ISIZE, 10: inputs per neuron.
- LSIZE, 10: neurons per layer.
- VALID, all ones (LSIZE*ISIZE bits): connection mask; bit gi*ISIZE+gj enables weight (neuron gi, input gj).
- WW, 8: stream word width in bits.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse; begins a load; honoured only in IDLE.
- abort  input  1  cancels a load in progress.
- w_data  input  WW  weight word; bit 0 is the lowest compacted index.
- w_valid  input  1  w_data valid.
- w_ready  output  1  loader accepts a word this cycle.
- e_weights  output  LSIZE*ISIZE  scattered weight vector; drives the layer's e_input.
- e_valid  output  1  e_weights holds a complete, new vector.
- e_ack  input  1  consumer has taken e_weights.
- busy  output  1  state is LOAD or HOLD.

Behaviour:
- Elaboration constants:
  - NV = popcount(VALID).
  - NW = ceil(NV/WW).
  - MAP[c] = position of the c-th set bit of VALID, in ascending order, for c = 0..NV-1. MAP is a constant table with no runtime computation.
- Reset (rst low, asynchronous): state IDLE; w_ready=0, e_valid=0, busy=0, e_weights=0, shadow=0, word_cnt=0.
- State IDLE:
  - w_ready=0.
  - start=1: clear shadow and word_cnt; go to LOAD. If NV=0, go directly to HOLD with e_weights=0.
- State LOAD:
  - w_ready=1.
  - Transfer occurs when w_valid & w_ready. For each k in 0..WW-1 with c = word_cnt*WW + k < NV: shadow[MAP[c]] <= w_data[k]. Bits with c >= NV are ignored. word_cnt increments.
  - Transfer of word NW-1 at cycle T: e_weights <= shadow with the final word merged, e_valid=1, state HOLD; all of this is visible at T+1, so latency is 1 cycle.
  - abort=1: return to IDLE, discard shadow and word_cnt, leave e_weights unchanged. abort takes priority over a simultaneous transfer, so that word is not taken.
- State HOLD:
  - w_ready=0; e_valid=1; e_weights stable.
  - e_ack=1: e_valid=0 next cycle; state IDLE.
- Positions with VALID=0 are always 0 in e_weights.
- e_weights keeps its value after e_ack until the next completed load. It is never partially updated.
- Ignored inputs:
  - start in LOAD or HOLD.
  - abort in IDLE or HOLD.
  - e_ack outside HOLD.
  - w_valid outside LOAD.
- start and e_ack in the same HOLD cycle: e_ack handled; start ignored.
- word_cnt width is clog2(NW+1). It never wraps, because the LOAD→HOLD transition occurs at word NW-1.
- Back-to-back words are accepted every cycle. w_valid gaps stall the load with no timeout.

Test Plan:
- Scatter with a sparse mask. Setup: ISIZE=4, LSIZE=2, VALID=8'b1011_0110 (NV=5), WW=4 (NW=2). Stimulus: start; word0=4'b1011; word1=4'b1111. Required: e_weights=8'hA6; e_valid rises 1 cycle after word1; excess bits of word1 ignored.
- Handshake and hold. Stimulus: after the load above, hold e_ack=0 for 10 cycles, then pulse e_ack. Required: e_weights=8'hA6 and e_valid=1 throughout the wait; e_valid=0 and busy=0 the next cycle; e_weights stays 8'hA6.
- Double buffering. Stimulus: start a second load; send word0=4'b0000, then w_valid=0 for 5 cycles, then word1=4'b0000. Required: e_weights=8'hA6 during the whole load; 8'h00 with e_valid=1 after completion.
- Abort. Stimulus: abort after word0 of a new load, with w_valid=1 in the same cycle. Required: word not accepted; state IDLE, w_ready=0; e_weights unchanged; the next full load produces the correct vector.
- Reset mid-load. Stimulus: rst low during LOAD and again during HOLD. Required: all outputs zero immediately; after release, start plus 2 words gives the correct vector.
- Defaults. Setup: ISIZE=LSIZE=10, all-ones VALID, WW=8 (NW=13). Stimulus: 13 random words. Required: e_weights equals the first 100 stream bits in index order; word 13 bits 4..7 ignored.
